alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered 8-bit arithmetic/logic unit: combinational operation select on operands A/B, result captured into output register R on each rising clock edge.
- Single-cycle latency: operation presented at edge N appears on R after edge N and is stable through edge N+1.
- Used as a leaf datapath block.
- Reference model for its checkers: R at edge N+1 equals f(op, A, B) sampled at edge N.

Parameters:
- WIDTH, 8, operand and result width in bits (all behaviour below stated for WIDTH=8; scales linearly).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- A      input   WIDTH  operand A
- B      input   WIDTH  operand B
- op     input   3      operation select
- R      output  WIDTH  registered result
- flags  output  4      {N,Z,V,C} registered status; present only with ALU_FLAGS_EN

Behaviour:
- Reset: rst_n low asynchronously forces R=0 (and flags=0); held while low. First capture on the first rising clk after rst_n deasserts.
- Reset mid-operation: clears R immediately regardless of clk; pending result is discarded, no replay.
- Every rising clk with rst_n high: R <= f(op,A,B). No enable, no handshake; R updates every cycle.
- Operation encoding (modulo 2^WIDTH, unsigned wrap):
  - 000 ADD: A+B, carry out discarded from R.
  - 001 NOT: ~A (B ignored).
  - 010 SUB: A-B, two's complement wrap.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 AND: A&B.
  - 110 SHL: A<<1, LSB filled 0, MSB dropped.
  - 111 SHR: A>>1 logical, MSB filled 0.
- All 8 codes defined; no X propagation for known inputs. Inputs changing between edges have no effect until the next edge.
- Combinational path: op/A/B to D of R only; no input-to-output combinational path.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: flags port exists, registered alongside R with identical timing and reset:
  - N = result MSB.
  - Z = (result==0).
  - C:
    - ADD: carry out.
    - SUB: borrow (A<B unsigned).
    - SHL: bit shifted out of MSB.
    - SHR: bit shifted out of LSB.
    - Logic ops: 0.
  - V: signed overflow for ADD/SUB, 0 otherwise.
- Undefined: no flags port, no flag logic; R behaviour identical.

Test Plan:
- Reset: drive rst_n=0 between edges with R nonzero -> R=0x00 immediately (no clock edge needed); stays 0 while rst_n=0.
- A=0xAA, B=0x55, op=000 for one edge -> next cycle R=0xFF. Then op=101 -> R=0x00.
- A=0xAA, B=0x55, op=001 -> R=0x55. Then op=010 -> R=0x55. Then op=011 -> R=0xFF. Then op=100 -> R=0xFF.
- A=0xAA: op=110 -> R=0x54; op=111 -> R=0x55. A=0xFF, B=0x01, op=000 -> R=0x00 (wrap); A=0x00, B=0x01, op=010 -> R=0xFF.
- Latency: change op on consecutive edges 000, 001, 101 -> R sequence 0xFF, 0x55, 0x00, each one cycle after its op; mid-cycle A/B glitch does not alter R.
- With ALU_FLAGS_EN: A=0xFF, B=0x01, ADD -> R=0x00, flags {N,Z,V,C}=0101. A=0x7F, B=0x01, ADD -> R=0x80, flags=1010.

Source files
------------

// File: rtl/alu_core.sv
// ============================================================================
// alu_core : registered WIDTH-bit ALU, one-cycle latency from op/A/B to R.
// Optional macro ALU_FLAGS_EN adds the registered {N,Z,V,C} flags port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH-1:0] R
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_NOT = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_AND = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_SHR = 3'b111;

    logic [WIDTH-1:0] r_result_q;
    logic [WIDTH-1:0] w_result_d;

    always_comb begin
        w_result_d = '0;
        case (op)
            c_OP_ADD: w_result_d = A + B;
            c_OP_NOT: w_result_d = ~A;
            c_OP_SUB: w_result_d = A - B;
            c_OP_OR:  w_result_d = A | B;
            c_OP_XOR: w_result_d = A ^ B;
            c_OP_AND: w_result_d = A & B;
            c_OP_SHL: w_result_d = {A[WIDTH-2:0], 1'b0};
            c_OP_SHR: w_result_d = {1'b0, A[WIDTH-1:1]};
            default:  w_result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= '0;
        end else begin
            r_result_q <= w_result_d;
        end
    end

    assign R = r_result_q;

`ifdef ALU_FLAGS_EN
    logic [3:0]     r_flags_q;
    logic [3:0]     w_flags_d;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_n;
    logic           w_z;
    logic           w_v;
    logic           w_c;

    // Extended-width add/sub expose carry and borrow in the top bit.
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        w_n = w_result_d[WIDTH-1];
        w_z = (w_result_d == '0);
        w_v = 1'b0;
        w_c = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_c = w_sum[WIDTH];
                w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_result_d[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_c = w_diff[WIDTH];
                w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_result_d[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SHL: w_c = A[WIDTH-1];
            c_OP_SHR: w_c = A[0];
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
        w_flags_d = {w_n, w_z, w_v, w_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_q <= '0;
        end else begin
            r_flags_q <= w_flags_d;
        end
    end

    assign flags = r_flags_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// tb_alu_core : directed self-checking bench for alu_core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic [7:0] R;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    alu_core #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .op    (op),
`ifdef ALU_FLAGS_EN
        .flags (flags),
`endif
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_r(input string tag, input logic [7:0] expected);
        checks_total++;
        assert (R === expected) checks_passed++;
        else $error("FAIL %s: observed R=%h expected R=%h", tag, R, expected);
    endtask

`ifdef ALU_FLAGS_EN
    task automatic check_f(input string tag, input logic [3:0] expected);
        checks_total++;
        assert (flags === expected) checks_passed++;
        else $error("FAIL %s: observed flags=%b expected flags=%b", tag, flags, expected);
    endtask
`endif

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expected, input string tag);
        op = o;
        A  = a;
        B  = b;
        @(posedge clk);
        #1;
        check_r(tag, expected);
    endtask

    initial begin
        rst_n = 1'b1;
        A     = 8'h00;
        B     = 8'h00;
        op    = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        check_r("reset_initial", 8'h00);
`ifdef ALU_FLAGS_EN
        check_f("reset_initial_flags", 4'b0000);
`endif
        A = 8'hAA; B = 8'h55; op = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_r("reset_held", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_r("reset_release_no_edge", 8'h00);

        step(3'b000, 8'hAA, 8'h55, 8'hFF, "add_aa_55");
        step(3'b101, 8'hAA, 8'h55, 8'h00, "and_aa_55");
        step(3'b001, 8'hAA, 8'h55, 8'h55, "not_aa");
        step(3'b010, 8'hAA, 8'h55, 8'h55, "sub_aa_55");
        step(3'b011, 8'hAA, 8'h55, 8'hFF, "or_aa_55");
        step(3'b100, 8'hAA, 8'h55, 8'hFF, "xor_aa_55");
        step(3'b110, 8'hAA, 8'h55, 8'h54, "shl_aa");
`ifdef ALU_FLAGS_EN
        check_f("shl_aa_flags", 4'b0001);
`endif
        step(3'b111, 8'hAA, 8'h55, 8'h55, "shr_aa");
`ifdef ALU_FLAGS_EN
        check_f("shr_aa_flags", 4'b0000);
`endif
        step(3'b000, 8'hFF, 8'h01, 8'h00, "add_wrap");
`ifdef ALU_FLAGS_EN
        check_f("add_wrap_flags", 4'b0101);
`endif
        step(3'b010, 8'h00, 8'h01, 8'hFF, "sub_wrap");
`ifdef ALU_FLAGS_EN
        check_f("sub_wrap_flags", 4'b1001);
`endif
        step(3'b000, 8'h7F, 8'h01, 8'h80, "add_overflow");
`ifdef ALU_FLAGS_EN
        check_f("add_overflow_flags", 4'b1010);
`endif

        // Back-to-back ops, with an A/B glitch inside the cycle of the first.
        op = 3'b000; A = 8'hAA; B = 8'h55;
        #2;
        A = 8'h13; B = 8'hC4;
        #1;
        check_r("glitch_no_effect_mid", 8'h80);
        A = 8'hAA; B = 8'h55;
        @(posedge clk);
        #1;
        check_r("lat_add", 8'hFF);
        step(3'b001, 8'hAA, 8'h55, 8'h55, "lat_not");
        step(3'b101, 8'hAA, 8'h55, 8'h00, "lat_and");

        // Asynchronous reset mid-cycle with R nonzero.
        step(3'b011, 8'hAA, 8'h55, 8'hFF, "pre_reset_or");
        #2;
        rst_n = 1'b0;
        #1;
        check_r("async_reset_mid", 8'h00);
`ifdef ALU_FLAGS_EN
        check_f("async_reset_mid_flags", 4'b0000);
`endif
        @(posedge clk);
        #1;
        check_r("async_reset_held", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b100, 8'h0F, 8'h3C, 8'h33, "post_reset_xor");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

`default_nettype wire
